// File: rtl/alu_multiword_seq.sv
// Multi-limb add/sub/rsb/cmp sequencer that drives the shared 32-bit ALU one
// limb per cycle, least-significant first, chaining the ALU carry through C_in.
module alu_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [32*WORDS-1:0]   OpA,
  input  logic [32*WORDS-1:0]   OpB,
  output logic                  Ready,
  output logic                  Busy,
  output logic [31:0]           Src_A,
  output logic [31:0]           Src_B,
  output logic [3:0]            ALUControl,
  output logic                  C_in,
  input  logic [31:0]           ALUResult,
  input  logic [3:0]            ALUFlags,
  output logic [32*WORDS-1:0]   Result,
  output logic [3:0]            Flags,
  output logic                  OutValid,
  input  logic                  OutReady
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_RSB = 2'b10, OP_CMP = 2'b11} op_e;

  state_e                 state;
  op_e                    op_q;
  logic [WORDS-1:0][31:0] a_q;
  logic [WORDS-1:0][31:0] b_q;
  logic [WORDS-1:0][31:0] res_q;
  logic [IW-1:0]          idx;
  logic                   carry_q;
  logic                   zacc_q;
  logic                   last_limb;
  logic                   first_limb;

  assign last_limb  = (idx == IW'(WORDS - 1));
  assign first_limb = (idx == '0);

  assign Ready    = (state == S_IDLE);
  assign Busy     = (state == S_RUN);
  assign OutValid = (state == S_DONE);
  assign Result   = res_q;

  // Limb 0 uses the non-carry opcodes so the ALU supplies the +1 for subtracts.
  always_comb begin
    Src_A      = '0;
    Src_B      = '0;
    ALUControl = 4'b1101;
    C_in       = 1'b0;
    if (state == S_RUN) begin
      Src_A = a_q[idx];
      Src_B = b_q[idx];
      C_in  = first_limb ? 1'b0 : carry_q;
      unique case (op_q)
        OP_ADD:         ALUControl = first_limb ? 4'b0100 : 4'b0101;
        OP_SUB, OP_CMP: ALUControl = first_limb ? 4'b0010 : 4'b0110;
        OP_RSB:         ALUControl = first_limb ? 4'b0011 : 4'b0111;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      Flags   <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            op_q    <= op_e'(Op);
            a_q     <= OpA;
            b_q     <= OpB;
            idx     <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          carry_q <= ALUFlags[1];
          zacc_q  <= zacc_q & ALUFlags[2];
          if (op_q != OP_CMP) res_q[idx] <= ALUResult;
          if (last_limb) begin
            Flags <= {ALUFlags[3], zacc_q & ALUFlags[2], ALUFlags[1], ALUFlags[0]};
            idx   <= '0;
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (OutReady) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Bench for alu_multiword_seq: a 32-bit ALU model closes the loop, and results
// are checked against whole-width arithmetic on the full operands.
module tb_alu_multiword_seq;

  localparam int W  = 4;
  localparam int NB = 32 * W;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          Start = 1'b0;
  logic [1:0]    Op = 2'b00;
  logic [NB-1:0] OpA = '0;
  logic [NB-1:0] OpB = '0;
  logic          OutReady = 1'b0;
  logic          Ready, Busy, C_in, OutValid;
  logic [31:0]   Src_A, Src_B, ALUResult;
  logic [3:0]    ALUControl, ALUFlags, Flags;
  logic [NB-1:0] Result;

  alu_multiword_seq #(.WORDS(W)) dut (
    .CLK(CLK), .RESETn(RESETn), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .Ready(Ready), .Busy(Busy), .Src_A(Src_A), .Src_B(Src_B),
    .ALUControl(ALUControl), .C_in(C_in), .ALUResult(ALUResult),
    .ALUFlags(ALUFlags), .Result(Result), .Flags(Flags),
    .OutValid(OutValid), .OutReady(OutReady)
  );

  always #5 CLK = ~CLK;

  // ARM-style 32-bit ALU: subtracts are x + ~y + carry.
  logic [31:0] ax, ay;
  logic        aci, arith;
  logic [32:0] asum;
  always_comb begin
    ax = Src_A; ay = Src_B; aci = 1'b0; arith = 1'b1;
    case (ALUControl)
      4'b0100: begin ax = Src_A; ay = Src_B;  aci = 1'b0; end
      4'b0101: begin ax = Src_A; ay = Src_B;  aci = C_in; end
      4'b0010: begin ax = Src_A; ay = ~Src_B; aci = 1'b1; end
      4'b0110: begin ax = Src_A; ay = ~Src_B; aci = C_in; end
      4'b0011: begin ax = Src_B; ay = ~Src_A; aci = 1'b1; end
      4'b0111: begin ax = Src_B; ay = ~Src_A; aci = C_in; end
      default: arith = 1'b0;
    endcase
    asum = {1'b0, ax} + {1'b0, ay} + 33'(aci);
    if (arith) begin
      ALUResult = asum[31:0];
      ALUFlags  = {asum[31], asum[31:0] == 32'd0, asum[32],
                   (ax[31] == ay[31]) && (asum[31] != ax[31])};
    end else begin
      ALUResult = Src_B;
      ALUFlags  = {Src_B[31], Src_B == 32'd0, 1'b0, 1'b0};
    end
  end

  int            checks = 0;
  int            errors = 0;
  logic [NB-1:0] exp_prev = '0;
  logic [NB-1:0] last_res;
  logic [3:0]    last_flags;

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
  endtask

  function automatic void model(input logic [1:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b,
                                input logic [NB-1:0] prev, output logic [NB-1:0] r, output logic [3:0] f);
    logic [NB:0]   s;
    logic [NB-1:0] d;
    logic          c, v;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        d = s[NB-1:0];
        c = s[NB];
        v = (a[NB-1] == b[NB-1]) && (d[NB-1] != a[NB-1]);
      end
      2'b10: begin
        d = b - a;
        c = (b >= a);
        v = (b[NB-1] != a[NB-1]) && (d[NB-1] != b[NB-1]);
      end
      default: begin
        d = a - b;
        c = (a >= b);
        v = (a[NB-1] != b[NB-1]) && (d[NB-1] != a[NB-1]);
      end
    endcase
    f = {d[NB-1], d == '0, c, v};
    r = (op == 2'b11) ? prev : d;
  endfunction

  function automatic logic [NB-1:0] rand_wide();
    logic [NB-1:0] v;
    for (int i = 0; i < W; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // poke: during backpressure pulse Start with new operands, then raise Start with the ack.
  task automatic run_op(input logic [1:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b,
                        input int hold, input bit poke);
    logic [NB-1:0] er;
    logic [3:0]    ef;
    logic [3:0]    code;
    int            cyc;
    model(op, a, b, exp_prev, er, ef);
    case (op)
      2'b00:   code = 4'b0100;
      2'b10:   code = 4'b0011;
      default: code = 4'b0010;
    endcase
    @(negedge CLK);
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(posedge CLK); #1;
    Start = 1'b0;
    check("busy_after_start", NB'(Busy), NB'(1));
    check("alucontrol_limb0", NB'(ALUControl), NB'(code));
    check("src_a_limb0", NB'(Src_A), NB'(a[31:0]));
    check("c_in_limb0", NB'(C_in), NB'(0));
    cyc = 0;
    while (!OutValid && cyc < 3 * W) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check("latency", NB'(cyc), NB'(W));
    check("result", Result, er);
    check("flags", NB'(Flags), NB'(ef));
    check("alucontrol_done", NB'(ALUControl), NB'(4'b1101));
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1) begin
        Start = 1'b1; OpA = ~a; OpB = ~b; Op = ~op;
      end
      @(posedge CLK); #1;
      Start = 1'b0;
      check("hold_valid", NB'(OutValid), NB'(1));
      check("hold_result", Result, er);
      check("hold_flags", NB'(Flags), NB'(ef));
    end
    last_res = Result;
    last_flags = Flags;
    exp_prev = er;
    OutReady = 1'b1;
    if (poke) Start = 1'b1;
    @(posedge CLK); #1;
    OutReady = 1'b0;
    Start = 1'b0;
    check("ready_after_ack", NB'(Ready), NB'(1));
    check("valid_after_ack", NB'(OutValid), NB'(0));
    check("busy_after_ack", NB'(Busy), NB'(0));
  endtask

  initial begin
    logic [NB-1:0] pat, ones, maxpos, one;
    #2;
    check("rst_ready", NB'(Ready), NB'(1));
    check("rst_busy", NB'(Busy), NB'(0));
    check("rst_valid", NB'(OutValid), NB'(0));
    check("rst_result", Result, '0);
    check("rst_flags", NB'(Flags), NB'(0));
    check("rst_alucontrol", NB'(ALUControl), NB'(4'b1101));
    check("rst_src_a", NB'(Src_A), NB'(0));
    check("rst_c_in", NB'(C_in), NB'(0));
    @(negedge CLK);
    RESETn = 1'b1;

    one = NB'(1);
    run_op(2'b00, NB'(32'hFFFF_FFFF), one, 0, 1'b0);
    check("add_chain_result", last_res, NB'(64'h1_0000_0000));
    check("add_chain_flags", NB'(last_flags), NB'(4'b0000));

    pat = rand_wide();
    run_op(2'b01, pat, pat, 0, 1'b0);
    check("sub_eq_flags", NB'(last_flags), NB'(4'b0110));

    ones = '1;
    run_op(2'b01, '0, one, 0, 1'b0);
    check("sub_borrow_result", last_res, ones);
    check("sub_borrow_flags", NB'(last_flags), NB'(4'b1000));
    run_op(2'b10, '0, one, 0, 1'b0);
    check("rsb_result", last_res, one);
    check("rsb_flags", NB'(last_flags), NB'(4'b0010));

    maxpos = {1'b0, {(NB-1){1'b1}}};
    run_op(2'b00, maxpos, one, 0, 1'b0);
    check("ovf_flags", NB'(last_flags), NB'(4'b1001));
    run_op(2'b11, NB'(5), NB'(5), 0, 1'b0);
    check("cmp_flags", NB'(last_flags), NB'(4'b0110));
    check("cmp_result_kept", last_res, ~maxpos);

    run_op(2'(($urandom)), rand_wide(), rand_wide(), 5, 1'b1);

    for (int n = 0; n < 24; n++)
      run_op(2'($urandom_range(0, 3)), rand_wide(), rand_wide(), $urandom_range(0, 2), 1'b0);

    // Reset after limbs 0 and 1 of an ADD have been processed.
    @(negedge CLK);
    Start = 1'b1; Op = 2'b00; OpA = rand_wide(); OpB = rand_wide();
    @(posedge CLK); #1;
    Start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESETn = 1'b0;
    #1;
    check("midrst_ready", NB'(Ready), NB'(1));
    check("midrst_busy", NB'(Busy), NB'(0));
    check("midrst_valid", NB'(OutValid), NB'(0));
    check("midrst_result", Result, '0);
    check("midrst_flags", NB'(Flags), NB'(0));
    check("midrst_alucontrol", NB'(ALUControl), NB'(4'b1101));
    check("midrst_src_b", NB'(Src_B), NB'(0));
    @(negedge CLK);
    RESETn = 1'b1;
    exp_prev = '0;
    run_op(2'b11, rand_wide(), rand_wide(), 0, 1'b0);
    check("post_rst_cmp_result", last_res, '0);
    run_op(2'b00, rand_wide(), rand_wide(), 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multiword_seq.md
# alu_multiword_seq

Multi-cycle sequencer that performs WORDS×32-bit add, subtract, reverse-subtract and compare on the existing 32-bit ALU. It issues one 32-bit limb per cycle, least-significant first, and chains the ALU carry flag through C_in. It sits beside the datapath ALU, owns that ALU's input ports while busy, and returns a wide result and NZCV flags through a valid/ready handshake.

## Interface
- WORDS, 4: number of 32-bit limbs. Legal range 2..8.
- CLK  in  1  clock; all state updates on the rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- Start  in  1  request; accepted only in IDLE.
- Op  in  2  operation: 00 ADD, 01 SUB (A−B), 10 RSB (B−A), 11 CMP (A−B, flags only).
- OpA, OpB  in  32*WORDS  operands; limb i is bits [32i+31:32i].
- Ready  out  1  high in IDLE.
- Busy  out  1  high in RUN.
- Src_A, Src_B  out  32  current limb of the latched operands, driven to the ALU.
- ALUControl  out  4  ALU opcode for the current limb.
- C_in  out  1  carry into the ALU.
- ALUResult  in  32  ALU result, combinational from this block's drive.
- ALUFlags  in  4  ALU {N,Z,C,V}.
- Result  out  32*WORDS  assembled result.
- Flags  out  4  final {N,Z,C,V}.
- OutValid  out  1  Result and Flags valid.
- OutReady  in  1  consumer accepts the result.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE → RUN** on Start=1.
  - Latch OpA, OpB and Op.
  - Clear limb index idx to 0, carry register to 0, and zero-accumulator to 1.
- **RUN:** drive Src_A = A[idx], Src_B = B[idx].
- **ALUControl for limb 0:**
  - ADD: 0100.
  - SUB and CMP: 0010.
  - RSB: 0011.
- **ALUControl for limbs 1..WORDS-1:**
  - ADD: 0101 (ADC).
  - SUB and CMP: 0110 (SBC).
  - RSB: 0111 (RSC).
- **C_in:**
  - 0 for limb 0; the ALU supplies its own +1 for 0010/0011.
  - The carry register for later limbs.
  - Subtract carry is ARM-style (C=1 means no borrow) and is chained unmodified.
- **Each RUN edge:**
  - Carry register ← ALUFlags[1].
  - Zero-accumulator ← zero-accumulator & ALUFlags[2].
  - Result limb idx ← ALUResult, except for CMP, where Result is left unchanged.
  - idx increments.
- **RUN → DONE** on the edge that processes idx = WORDS-1. On that edge Flags are loaded as:
  - N = ALUFlags[3] of the top limb.
  - Z = zero-accumulator & ALUFlags[2].
  - C = ALUFlags[1] of the top limb.
  - V = ALUFlags[0] of the top limb.
- **DONE:** OutValid=1. Result and Flags are held stable until OutValid && OutReady; on that edge the FSM goes to IDLE.
- **Start outside IDLE** is ignored; no queuing.
- **Outside RUN:** Src_A = Src_B = 0, ALUControl = 1101 (MOV), C_in = 0.
- **Result and Flags** keep their last values in IDLE and are overwritten only by the next operation.

## Timing
- **Reset values:** state IDLE, Ready=1, Busy=0, OutValid=0, Result=0, Flags=0, idx=0, Src_A=Src_B=0, ALUControl=1101, C_in=0.
- **Latency:**
  - Start sampled at edge k.
  - Limbs are processed on edges k+1..k+WORDS.
  - OutValid rises after edge k+WORDS.
  - Minimum start-to-start spacing is WORDS+2 cycles, with OutReady held at 1.
- **Backpressure:** OutValid stays high with a constant payload for any number of cycles of OutReady=0.
- **ALU path:** the ALU is combinational. The Src/ALUControl/C_in → ALUResult/ALUFlags path must close in one cycle; the drive outputs come from registers or from idx-muxed registers.
- **Reset mid-operation:** RESETn low in RUN or DONE immediately forces all reset values; the partial result is discarded.
- **Start and OutReady together in DONE:** DONE→IDLE only; that Start is not accepted.

## Test plan
- **ADD carry chain:** WORDS=2, ADD, A=0x00000000_FFFFFFFF, B=0x00000000_00000001 → Result 0x00000001_00000000, Flags N0 Z0 C0 V0, OutValid 2 cycles after the Start edge.
- **SUB equal operands:** WORDS=2, SUB, A=B=0x12345678_9ABCDEF0 → Result 0, Flags N0 Z1 C1 V0.
- **SUB borrow propagation:** WORDS=2, SUB, A=0, B=1 → Result 0xFFFFFFFF_FFFFFFFF, N1 Z0 C0 V0. RSB with the same operands → Result 1, C1.
- **Signed overflow:** WORDS=2, ADD, A=0x7FFFFFFF_FFFFFFFF, B=1 → Result 0x80000000_00000000, N1 V1. CMP with A=5, B=5 → Flags Z1 C1, Result unchanged from the prior operation.
- **Backpressure and ignored Start:** OutReady=0 for 5 cycles in DONE with a Start pulse and new operands → payload unchanged, no new operation. The FSM returns to IDLE on the first OutReady=1 edge.
- **Reset mid-RUN:** RESETn low after limb 1 of a WORDS=4 ADD → all outputs at reset values. After release, a fresh operation completes correctly.
